// File: rtl/ttc_readout_trig_filter.sv
// TTC trigger filter: pairs each L1A with its broadcast trigger-type word and
// forwards only triggers of the selected readout type to the acquisition controller.
module ttc_readout_trig_filter #(
   parameter int TYPE_TIMEOUT = 32,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ttc_l1a,
   input  logic                 ttc_bcmd_valid,
   input  logic [7:0]           ttc_bcmd,
   input  logic                 filter_en,
   input  logic [4:0]           readout_type,
   input  logic                 ttc_acq_ready,
   output logic                 ttc_trigger,
   output logic [4:0]           ttc_trig_type,
   output logic [23:0]          ttc_trig_num,
   output logic [CNT_WIDTH-1:0] filtered_cnt,
   output logic [CNT_WIDTH-1:0] dropped_cnt,
   output logic                 type_timeout_err,
   output logic                 overlap_err,
   output logic [3:0]           state
);

   localparam int TW = $clog2(TYPE_TIMEOUT + 1);

   typedef enum logic [3:0] {
      S_IDLE      = 4'b0001,
      S_WAIT_TYPE = 4'b0010,
      S_EVAL      = 4'b0100,
      S_HOLD      = 4'b1000
   } state_e;

   state_e                 state_q, state_d;
   logic [23:0]            evt_cnt_q, evt_cnt_d;
   logic [23:0]            pend_num_q, pend_num_d;
   logic [4:0]             pend_type_q, pend_type_d;
   logic [TW-1:0]          timer_q, timer_d;
   logic                   trig_q, trig_d;
   logic [4:0]             trig_type_q, trig_type_d;
   logic [23:0]            trig_num_q, trig_num_d;
   logic [CNT_WIDTH-1:0]   filt_q, filt_d, drop_q, drop_d;
   logic                   tmo_q, tmo_d, ovl_q, ovl_d;
   logic                   ecr, type_word, inc_drop, inc_filt;

   assign ecr       = ttc_bcmd_valid && (ttc_bcmd == 8'h02);
   assign type_word = ttc_bcmd_valid && (ttc_bcmd[1:0] == 2'b00) && !ecr;

   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      state_d     = state_q;
      evt_cnt_d   = evt_cnt_q;
      pend_num_d  = pend_num_q;
      pend_type_d = pend_type_q;
      timer_d     = timer_q;
      trig_d      = 1'b0;
      trig_type_d = trig_type_q;
      trig_num_d  = trig_num_q;
      tmo_d       = tmo_q;
      ovl_d       = ovl_q;
      inc_drop    = 1'b0;
      inc_filt    = 1'b0;

      // ECR wins over the increment but a coincident L1A still counts as event 1.
      if (ecr)          evt_cnt_d = {23'd0, ttc_l1a};
      else if (ttc_l1a) evt_cnt_d = evt_cnt_q + 24'd1;

      unique case (state_q)
         S_IDLE: begin
            if (ttc_l1a) begin
               pend_num_d = evt_cnt_d;
               timer_d    = '0;
               state_d    = S_WAIT_TYPE;
            end
         end
         S_WAIT_TYPE: begin
            if (ttc_l1a) begin
               ovl_d      = 1'b1;
               inc_drop   = 1'b1;
               pend_num_d = evt_cnt_d;
               timer_d    = '0;
            end else if (type_word) begin
               pend_type_d = ttc_bcmd[6:2];
               state_d     = S_EVAL;
            end else if (timer_q == TW'(TYPE_TIMEOUT - 1)) begin
               tmo_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_EVAL: begin
            inc_drop = ttc_l1a;
            if (!filter_en || (pend_type_q != readout_type)) begin
               inc_filt = 1'b1;
               state_d  = S_IDLE;
            end else if (ttc_acq_ready) begin
               trig_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            inc_drop = ttc_l1a;
            if (ttc_acq_ready) begin
               trig_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (trig_d) begin
         trig_type_d = pend_type_q;
         trig_num_d  = pend_num_q;
      end

      filt_d = (inc_filt && filt_q != '1) ? filt_q + 1'b1 : filt_q;
      drop_d = (inc_drop && drop_q != '1) ? drop_q + 1'b1 : drop_q;
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (reset) begin
         state_q     <= S_IDLE;
         evt_cnt_q   <= '0;
         pend_num_q  <= '0;
         pend_type_q <= '0;
         timer_q     <= '0;
         trig_q      <= 1'b0;
         trig_type_q <= '0;
         trig_num_q  <= '0;
         filt_q      <= '0;
         drop_q      <= '0;
         tmo_q       <= 1'b0;
         ovl_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         evt_cnt_q   <= evt_cnt_d;
         pend_num_q  <= pend_num_d;
         pend_type_q <= pend_type_d;
         timer_q     <= timer_d;
         trig_q      <= trig_d;
         trig_type_q <= trig_type_d;
         trig_num_q  <= trig_num_d;
         filt_q      <= filt_d;
         drop_q      <= drop_d;
         tmo_q       <= tmo_d;
         ovl_q       <= ovl_d;
      end
   end

   assign ttc_trigger      = trig_q;
   assign ttc_trig_type    = trig_type_q;
   assign ttc_trig_num     = trig_num_q;
   assign filtered_cnt     = filt_q;
   assign dropped_cnt      = drop_q;
   assign type_timeout_err = tmo_q;
   assign overlap_err      = ovl_q;
   assign state            = state_q;

endmodule

// File: tb/tb_ttc_readout_trig_filter.sv
// Directed bench for ttc_readout_trig_filter: each scenario drives TTC strobes
// and compares outputs with hand-computed values.
module tb_ttc_readout_trig_filter;

   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          ttc_l1a = 1'b0;
   logic          ttc_bcmd_valid = 1'b0;
   logic [7:0]    ttc_bcmd = 8'h00;
   logic          filter_en = 1'b0;
   logic [4:0]    readout_type = 5'h00;
   logic          ttc_acq_ready = 1'b0;
   logic          ttc_trigger;
   logic [4:0]    ttc_trig_type;
   logic [23:0]   ttc_trig_num;
   logic [CW-1:0] filtered_cnt, dropped_cnt;
   logic          type_timeout_err, overlap_err;
   logic [3:0]    state;

   int n_checks = 0;
   int n_errors = 0;
   int trig_pulses = 0;
   int p0;

   ttc_readout_trig_filter #(.TYPE_TIMEOUT(32), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset), .ttc_l1a(ttc_l1a), .ttc_bcmd_valid(ttc_bcmd_valid),
      .ttc_bcmd(ttc_bcmd), .filter_en(filter_en), .readout_type(readout_type),
      .ttc_acq_ready(ttc_acq_ready), .ttc_trigger(ttc_trigger), .ttc_trig_type(ttc_trig_type),
      .ttc_trig_num(ttc_trig_num), .filtered_cnt(filtered_cnt), .dropped_cnt(dropped_cnt),
      .type_timeout_err(type_timeout_err), .overlap_err(overlap_err), .state(state)
   );

   always #12.5 clk = ~clk;

   always @(negedge clk) if (ttc_trigger) trig_pulses <= trig_pulses + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      ttc_l1a = 1'b0;
      ttc_bcmd_valid = 1'b0;
      ttc_bcmd = 8'h00;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic l1a_pulse();
      ttc_l1a = 1'b1;
      step();
      ttc_l1a = 1'b0;
   endtask

   task automatic send_bcmd(input logic [7:0] cmd, input logic with_l1a);
      ttc_bcmd_valid = 1'b1;
      ttc_bcmd = cmd;
      ttc_l1a = with_l1a;
      step();
      ttc_bcmd_valid = 1'b0;
      ttc_bcmd = 8'h00;
      ttc_l1a = 1'b0;
   endtask

   task automatic type_word(input logic [4:0] t);
      send_bcmd({1'b0, t, 2'b00}, 1'b0);
   endtask

   initial begin
      // Reset state
      do_reset();
      check("rst_state", state, 4'b0001);
      check("rst_trig", ttc_trigger, 0);
      check("rst_num", ttc_trig_num, 0);
      check("rst_type", ttc_trig_type, 0);
      check("rst_cnts", {filtered_cnt, dropped_cnt}, 0);
      check("rst_flags", {type_timeout_err, overlap_err}, 0);

      // Basic forward: type word 3 cycles after L1A, trigger 2 cycles after type word
      filter_en = 1'b1;
      readout_type = 5'h05;
      ttc_acq_ready = 1'b1;
      p0 = trig_pulses;
      l1a_pulse();
      check("fwd_wait", state, 4'b0010);
      step();
      step();
      type_word(5'h05);
      check("fwd_eval", state, 4'b0100);
      check("fwd_lat1", ttc_trigger, 0);
      step();
      check("fwd_trig", ttc_trigger, 1);
      check("fwd_type", ttc_trig_type, 5'h05);
      check("fwd_num", ttc_trig_num, 1);
      check("fwd_idle", state, 4'b0001);
      step();
      check("fwd_one_cycle", ttc_trigger, 0);
      send_bcmd(8'h02, 1'b0);
      check("ecr_keeps_num", ttc_trig_num, 1);
      check("ecr_keeps_type", ttc_trig_type, 5'h05);
      check("fwd_pulses", trig_pulses - p0, 1);

      // Non-matching type is filtered
      p0 = trig_pulses;
      l1a_pulse();
      type_word(5'h01);
      step();
      check("filt_state", state, 4'b0001);
      check("filt_cnt", filtered_cnt, 1);
      step();
      check("filt_no_trig", trig_pulses - p0, 0);

      // Type timeout
      do_reset();
      p0 = trig_pulses;
      l1a_pulse();
      repeat (31) step();
      check("tmo_still_wait", state, 4'b0010);
      check("tmo_not_yet", type_timeout_err, 0);
      step();
      check("tmo_idle", state, 4'b0001);
      check("tmo_err", type_timeout_err, 1);
      check("tmo_no_trig", trig_pulses - p0, 0);
      l1a_pulse();
      type_word(5'h05);
      step();
      check("tmo_next_trig", ttc_trig_num, 2);
      check("tmo_err_sticky", type_timeout_err, 1);

      // Overlapping L1A in WAIT_TYPE replaces pending trigger
      do_reset();
      l1a_pulse();
      l1a_pulse();
      check("ovl_err", overlap_err, 1);
      check("ovl_drop", dropped_cnt, 1);
      type_word(5'h05);
      step();
      check("ovl_trig", ttc_trigger, 1);
      check("ovl_num", ttc_trig_num, 2);

      // Hold with not-ready, drop three L1As, then release
      do_reset();
      ttc_acq_ready = 1'b0;
      l1a_pulse();
      type_word(5'h05);
      step();
      check("hold_state", state, 4'b1000);
      repeat (3) l1a_pulse();
      check("hold_still", state, 4'b1000);
      check("hold_drop", dropped_cnt, 3);
      check("hold_no_trig", ttc_trigger, 0);
      ttc_acq_ready = 1'b1;
      step();
      check("hold_trig", ttc_trigger, 1);
      check("hold_num", ttc_trig_num, 1);
      check("hold_idle", state, 4'b0001);
      l1a_pulse();
      type_word(5'h05);
      step();
      check("hold_next_num", ttc_trig_num, 5);

      // Counter wrap and ECR coincident with L1A
      do_reset();
      force dut.evt_cnt_q = 24'hFFFFFF;
      #1;
      release dut.evt_cnt_q;
      l1a_pulse();
      type_word(5'h05);
      step();
      check("wrap_num", ttc_trig_num, 0);
      l1a_pulse();
      type_word(5'h05);
      step();
      check("post_wrap_num", ttc_trig_num, 1);
      send_bcmd(8'h02, 1'b1);
      type_word(5'h05);
      step();
      check("ecr_l1a_trig", ttc_trigger, 1);
      check("ecr_l1a_num", ttc_trig_num, 1);

      // Reset while holding
      do_reset();
      ttc_acq_ready = 1'b0;
      l1a_pulse();
      type_word(5'h05);
      step();
      check("rh_hold", state, 4'b1000);
      p0 = trig_pulses;
      reset = 1'b1;
      ttc_acq_ready = 1'b1;
      step();
      check("rh_state", state, 4'b0001);
      check("rh_trig", ttc_trigger, 0);
      check("rh_outs", {ttc_trig_type, ttc_trig_num, filtered_cnt, dropped_cnt}, 0);
      reset = 1'b0;
      step();
      check("rh_after_trig", ttc_trigger, 0);
      check("rh_after_state", state, 4'b0001);
      step();
      check("rh_no_pulse", trig_pulses - p0, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
